// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-and-add unsigned multiplier.
// Each RUN cycle performs one conditional add and one shift. The 2*WIDTH-bit
// product, its zero flag and a single-cycle done pulse are all registered.
// Optional feature macro: MULT_EARLY_TERM_EN. When it is defined, RUN stops as
// soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             zero_flag
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 last_iter;

  // NOR of every product bit.
  function automatic logic is_zero(input logic [2*WIDTH-1:0] v);
    return ~|v;
  endfunction

  // Accumulator value after this iteration's conditional add. The carry-out
  // cannot occur because the product always fits in 2*WIDTH bits.
  always_comb begin
    acc_sum = acc;
    if (mplier[0]) acc_sum = acc + mcand;
  end

  // The final iteration is taken on the count limit. With early termination,
  // it is also taken when no set multiplier bits remain after this shift.
  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif
  end

  // Sequencer FSM. The datapath registers and the registered outputs are
  // updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      prod_hi   <= '0;
      prod_lo   <= '0;
      zero_flag <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            // The product is captured on the same edge that enters DONE.
            // This makes it valid for the whole done cycle.
            {prod_hi, prod_lo} <= acc_sum;
            zero_flag          <= is_zero(acc_sum);
            busy               <= 1'b0;
            done               <= 1'b1;
            state              <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl.
// A scoreboard is checked against a plain-arithmetic reference model.
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, zero_flag;
  logic [W-1:0] prod_hi, prod_lo;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           zero;
    int             done_edge;
  } exp_t;

  exp_t           q[$];
  int             edges = 0;
  int             checks = 0;
  int             errors = 0;
  bit             mon_en = 1'b0;
  logic [2*W-1:0] hold_prod = '0;
  logic           hold_zero = 1'b1;

  always @(posedge clk) edges++;

  // Iteration count from the multiplier value alone.
  function automatic int n_iter(input logic [W-1:0] y);
`ifdef MULT_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (y[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Issue one operation once ready is seen; the task returns after acceptance.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: ready=%b never reached required 1", ready);
      return;
    end
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    e.prod      = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    e.zero      = (e.prod == '0);
    e.done_edge = edges + n_iter(y);
    q.push_back(e);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Monitor: checks the control outputs every cycle, checks the product on done,
  // and checks that results hold in all other cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] exp_ctrl;
      bit         fire;
      exp_ctrl = 3'b100;
      fire     = 1'b0;
      if (q.size() > 0 && edges > q[0].done_edge) begin
        checks++;
        errors++;
        $display("FAIL late_done: edge=%0d done still pending, required at edge %0d",
                 edges, q[0].done_edge);
        void'(q.pop_front());
      end
      if (q.size() > 0) begin
        if (edges < q[0].done_edge) exp_ctrl = 3'b010;
        else begin
          exp_ctrl = 3'b001;
          fire     = 1'b1;
        end
      end
      checks++;
      if ({ready, busy, done} !== exp_ctrl) begin
        errors++;
        $display("FAIL ctrl: edge=%0d ready/busy/done=%b required %b",
                 edges, {ready, busy, done}, exp_ctrl);
      end
      if (fire) begin
        checks++;
        if ({prod_hi, prod_lo} !== q[0].prod || zero_flag !== q[0].zero) begin
          errors++;
          $display("FAIL product: got %h zero=%b required %h zero=%b",
                   {prod_hi, prod_lo}, zero_flag, q[0].prod, q[0].zero);
        end
        hold_prod = q[0].prod;
        hold_zero = q[0].zero;
        void'(q.pop_front());
      end else begin
        checks++;
        if ({prod_hi, prod_lo} !== hold_prod || zero_flag !== hold_zero) begin
          errors++;
          $display("FAIL hold: edge=%0d got %h zero=%b required %h zero=%b",
                   edges, {prod_hi, prod_lo}, zero_flag, hold_prod, hold_zero);
        end
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed cases.
    do_op(32'd3, 32'd5);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(32'h12345678, 32'h0);
    do_op(32'h0, 32'hFFFFFFFF);
    do_op(32'd1, 32'd1);

    // A start pulse during RUN must be ignored.
    do_op(32'hDEADBEEF, 32'h80000001);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a = 32'd7;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;

    // Back-to-back operations: the second start arrives in the first ready cycle.
    do_op(32'd2, 32'd3);
    do_op(32'd6, 32'd7);

    // Reset in the middle of an operation.
    do_op(32'h0BADF00D, 32'hF0000000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    hold_prod = '0;
    hold_zero = 1'b1;
    rst = 1'b0;

    // Random operations. Small multipliers exercise short early-terminate runs.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = $urandom;
      if (i % 3 == 0) y = y >> $urandom_range(31, 20);
      if (i % 7 == 0) x = '0;
      do_op(x, y);
    end

    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d operations outstanding, required 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle shift-and-add multiplier sequencer built around the team's WIDTH-bit adder and zero-detect datapath.
- Accepts two unsigned operands on a start handshake and iterates one add/shift step per cycle.
- Returns a registered 2*WIDTH-bit product with a zero flag and a one-cycle done pulse.
- Used by ALU/top-level control wherever a multiply is needed without a combinational array.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; iteration counter sized clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse when product becomes valid
- prod_hi  output  WIDTH  upper half of product
- prod_lo  output  WIDTH  lower half of product
- zero_flag  output  1  1 when the full 2*WIDTH product equals 0

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, prod_hi=0, prod_lo=0, zero_flag=1. All internal registers are cleared.
- Internal registers: mcand (2*WIDTH), mplier (WIDTH), acc (2*WIDTH), cnt.
- FSM states:
  - IDLE: if start=1, load mcand={0,a}, mplier=b, acc=0, cnt=0, then go to RUN. If start=0, stay in IDLE.
  - RUN, one iteration per cycle:
    - if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, carry-out discarded; it cannot overflow);
    - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
    - The last iteration is taken when cnt == WIDTH-1, or on the early-terminate condition (see Optional Feature). On the last iteration, go to DONE.
  - DONE: done=1 for exactly this cycle. {prod_hi,prod_lo} and zero_flag are loaded from the final acc on the clock edge that enters DONE, so they are valid while done=1. Next state is unconditionally IDLE.
- Latency: start sampled at edge 0 -> RUN cycles 1..N -> done=1 in cycle N+1 -> ready=1 in cycle N+2.
  - Without the optional feature, N=WIDTH (done in cycle 33 for WIDTH=32).
- Results hold their values until the next DONE or reset. They do not change during RUN.
- Operands are captured only at start acceptance. Changes on a/b afterwards have no effect.
- start while busy or in DONE is ignored: no queueing, no effect on the current operation.
- Reset mid-operation aborts the operation. All outputs return to their reset values on that edge, and no done pulse is emitted.
- zero_flag is the NOR of all 2*WIDTH product bits, computed from the final acc and registered alongside it. It is never combinational from inputs.
- Back-to-back: start asserted in the first ready cycle after DONE is accepted normally.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined: RUN also ends when the post-shift multiplier is zero (mplier[WIDTH-1:1]==0) on the current iteration. Then N = max(1, position of highest set bit of b + 1); b=0 or b=1 gives N=1, done in cycle 2. Product value is identical to the non-EN build.
- Undefined: always exactly WIDTH iterations, so latency is data-independent.

Test Plan:
- a=3, b=5, start 1 cycle -> done in cycle 33 (non-EN) or cycle 4 (EN, N=3); prod_hi=0, prod_lo=15, zero_flag=0.
- a=FFFFFFFF, b=FFFFFFFF -> prod_hi=FFFFFFFE, prod_lo=00000001, done in cycle 33 in both builds.
- a=12345678, b=0 -> product 0, zero_flag=1; done in cycle 2 (EN) or 33 (non-EN). Also run a=0, b=FFFFFFFF -> zero_flag=1.
- start pulsed in cycle 5 with a=7, b=7 during an operation -> ignored; the original result is unchanged and exactly one done pulse occurs.
- rst asserted in cycle 10 of an operation -> next cycle ready=1, busy=0, done=0, prod=0, zero_flag=1; no done pulse follows.
- Two operations back-to-back, second start in the first ready cycle (2*3 then 6*7) -> products 6 then 42, two single-cycle done pulses, prod holds 6 between them.
